// File: rtl/dco_lock_ctrl.sv
// dco_lock_ctrl: steps the DCO setting one notch at a time until the rising-edge
// count of dco_fb over a fixed window lands within target +/- tol.
module dco_lock_ctrl #(
  parameter int WINDOW    = 256,
  parameter int SETTLE    = 64,
  parameter int CNT_W     = 8,
  parameter int START_SEL = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] target,
  input  logic [3:0]       tol,
  input  logic             dco_fb,
  output logic [7:0]       dco_code,
  output logic             busy,
  output logic             locked,
  output logic             fail,
  output logic [CNT_W-1:0] meas_count,
  output logic             meas_valid
);
  localparam int CW = CNT_W + 1;
  localparam logic [3:0] START = 4'(START_SEL);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE - 1);
  localparam logic [15:0] WIN_LAST = 16'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  typedef enum logic [2:0] {S_IDLE, S_APPLY, S_SETTLE, S_MEAS, S_EVAL, S_LOCKED, S_FAIL} state_t;
  typedef enum logic [1:0] {DIR_NONE, DIR_SLOWER, DIR_FASTER} dir_t;
  state_t state_q, state_d;
  dir_t dir_q, dir_d;
  logic [3:0] sel_q, sel_d;
  logic [7:0] code_q, code_d;
  logic [15:0] tmr_q, tmr_d;
  logic [CNT_W-1:0] ecnt_q, ecnt_d, ecnt_inc, meas_count_q, meas_count_d;
  logic meas_valid_q, meas_valid_d, fb_q, rise;
  logic [CW-1:0] hi, lo, m9, t9, tl9;
  logic slower, faster, out_of_range, reversal;
  function automatic logic [7:0] map(input logic [3:0] k);
    return k[3] ? 8'h00 : 8'h01 << k[2:0];
  endfunction
  assign rise = dco_fb & ~fb_q;
  assign ecnt_inc = (rise && ecnt_q != CNT_MAX) ? ecnt_q + CNT_W'(1) : ecnt_q;
  // window limits in one extra bit so target+tol cannot wrap
  assign t9 = {1'b0, target};
  assign tl9 = CW'(tol);
  assign m9 = {1'b0, meas_count_q};
  assign hi = t9 + tl9;
  assign lo = t9 >= tl9 ? t9 - tl9 : '0;
  assign slower = m9 > hi;
  assign faster = m9 < lo;
  assign out_of_range = (slower && sel_q == 4'd8) || (faster && sel_q == 4'd0);
  assign reversal = (slower && dir_q == DIR_FASTER) || (faster && dir_q == DIR_SLOWER);
  always_comb begin
    state_d = state_q;
    sel_d = sel_q;
    dir_d = dir_q;
    tmr_d = tmr_q;
    ecnt_d = ecnt_q;
    meas_count_d = meas_count_q;
    meas_valid_d = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
      tmr_d = '0;
      ecnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE, S_LOCKED, S_FAIL: if (start) begin
          state_d = S_APPLY;
          sel_d = START;
          dir_d = DIR_NONE;
        end
        S_APPLY: begin
          state_d = S_SETTLE;
          tmr_d = '0;
        end
        S_SETTLE: begin
          tmr_d = tmr_q == SETTLE_LAST ? '0 : tmr_q + 16'd1;
          ecnt_d = '0;
          state_d = tmr_q == SETTLE_LAST ? S_MEAS : S_SETTLE;
        end
        S_MEAS: if (tmr_q == WIN_LAST) begin
          meas_count_d = ecnt_inc;
          meas_valid_d = 1'b1;
          tmr_d = '0;
          ecnt_d = '0;
          state_d = S_EVAL;
        end else begin
          ecnt_d = ecnt_inc;
          tmr_d = tmr_q + 16'd1;
        end
        S_EVAL: if (!slower && !faster) state_d = S_LOCKED;
        else if (out_of_range || reversal) state_d = S_FAIL;
        else begin
          sel_d = slower ? sel_q + 4'd1 : sel_q - 4'd1;
          dir_d = slower ? DIR_SLOWER : DIR_FASTER;
          state_d = S_APPLY;
        end
        default: state_d = S_IDLE;
      endcase
    end
    code_d = map(sel_d);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sel_q <= START;
      dir_q <= DIR_NONE;
      code_q <= map(START);
      tmr_q <= '0;
      ecnt_q <= '0;
      meas_count_q <= '0;
      meas_valid_q <= 1'b0;
      fb_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      dir_q <= dir_d;
      code_q <= code_d;
      tmr_q <= tmr_d;
      ecnt_q <= ecnt_d;
      meas_count_q <= meas_count_d;
      meas_valid_q <= meas_valid_d;
      fb_q <= dco_fb;
    end
  end
  assign dco_code = code_q;
  assign busy = state_q inside {S_APPLY, S_SETTLE, S_MEAS, S_EVAL};
  assign locked = state_q == S_LOCKED;
  assign fail = state_q == S_FAIL;
  assign meas_count = meas_count_q;
  assign meas_valid = meas_valid_q;
endmodule

// File: tb/tb_dco_lock_ctrl.sv
// tb_dco_lock_ctrl: periodic DCO model driven by dco_code; a reference model predicts
// each window count and the final outcome, and a monitor checks them as they appear.
module tb_dco_lock_ctrl;
  localparam int S = 64;
  localparam int W = 256;
  logic clk = 0, rst_n = 0, start = 0, abort = 0, dco_fb = 0;
  logic [7:0] target = 0;
  logic [3:0] tol = 0;
  logic [7:0] dco_code, meas_count;
  logic busy, locked, fail, meas_valid;
  int cyc = 0, checks = 0, failures = 0, mv_cnt = 0;
  int ptab[9];
  typedef struct {bit fin; int val; int code; int at;} exp_t;
  exp_t q[$];
  bit done_q = 0;
  dco_lock_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .target(target), .tol(tol),
    .dco_fb(dco_fb), .dco_code(dco_code), .busy(busy), .locked(locked), .fail(fail),
    .meas_count(meas_count), .meas_valid(meas_valid)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic int code_idx(input logic [7:0] c);
    if (c == 8'h00) return 8;
    for (int i = 0; i < 8; i++) if (c == (8'h01 << i)) return i;
    return -1;
  endfunction
  function automatic bit fbv(input int k, input int idx);
    int p;
    p = idx < 0 ? 6 : ptab[idx];
    return (k % p) < (p / 2);
  endfunction
  always @(negedge clk) dco_fb = fbv(cyc, code_idx(dco_code));
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at cycle %0d", name, act, exp, cyc);
    end
  endtask
  // Predict the whole attempt from the algorithm: window k of a step based at b covers
  // cycles [b+2+S, b+2+S+W); the next step starts 2+S+W cycles later.
  task automatic push_model(input int s, input int tg, input int tl);
    int sel, last, b, c, hi, lo, dir;
    sel = 4; last = 0; b = s;
    for (int step = 0; step < 12; step++) begin
      c = 0;
      for (int k = b + 2 + S; k < b + 2 + S + W; k++) if (fbv(k, sel) && !fbv(k - 1, sel)) c++;
      if (c > 255) c = 255;
      q.push_back('{0, c, 0, b + 2 + S + W});
      hi = tg + tl;
      lo = tg > tl ? tg - tl : 0;
      dir = c > hi ? 1 : (c < lo ? -1 : 0);
      if (dir == 0) begin
        q.push_back('{1, 1, sel == 8 ? 0 : (1 << sel), b + 3 + S + W});
        return;
      end
      if ((dir == 1 && sel == 8) || (dir == -1 && sel == 0) || (last != 0 && dir == -last)) begin
        q.push_back('{1, 0, sel == 8 ? 0 : (1 << sel), b + 3 + S + W});
        return;
      end
      sel += dir; last = dir; b += 2 + S + W;
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (meas_valid) begin
      mv_cnt++;
      if (q.size() == 0 || q[0].fin) chk("meas_valid_unexpected", 1, 0);
      else begin
        e = q.pop_front();
        chk("meas_count", int'(meas_count), e.val);
        chk("meas_cycle", cyc, e.at);
      end
    end
    if ((locked || fail) && !done_q) begin
      if (q.size() == 0 || !q[0].fin) chk("final_unexpected", 1, 0);
      else begin
        e = q.pop_front();
        chk("final_locked", int'(locked), e.val);
        chk("final_fail", int'(fail), 1 - e.val);
        chk("final_code", int'(dco_code), e.code);
        chk("final_cycle", cyc, e.at);
        chk("final_busy", int'(busy), 0);
      end
    end
    done_q = locked || fail;
  end
  task automatic launch(input int tg, input int tl, output int s);
    @(negedge clk);
    target = 8'(tg); tol = 4'(tl); start = 1;
    s = cyc;
    push_model(s, tg, tl);
    @(negedge clk);
    start = 0;
  endtask
  task automatic run(input int tg, input int tl, input bit poke);
    int s;
    launch(tg, tl, s);
    if (poke) begin
      repeat (100) @(negedge clk);
      start = 1;
      @(negedge clk);
      start = 0;
    end
    for (int i = 0; i < 4000 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      chk("run_timeout", q.size(), 0);
      q.delete();
    end
    repeat (2) @(negedge clk);
  endtask
  task automatic wait_until(input int t);
    for (int i = 0; i < 3000 && cyc < t; i++) @(negedge clk);
  endtask
  initial begin
    int s, r, tg;
    ptab = '{8, 10, 12, 14, 16, 20, 32, 64, 124};
    repeat (3) @(negedge clk);
    chk("rst_code", int'(dco_code), 'h10);
    chk("rst_busy", int'(busy), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_fail", int'(fail), 0);
    chk("rst_meas_count", int'(meas_count), 0);
    chk("rst_meas_valid", int'(meas_valid), 0);
    rst_n = 1;
    run(16, 1, 0);
    chk("t16_locked", int'(locked), 1);
    chk("t16_code", int'(dco_code), 'h10);
    mv_cnt = 0;
    run(32, 1, 1);
    chk("t32_pulses", mv_cnt, 5);
    chk("t32_locked", int'(locked), 1);
    chk("t32_code", int'(dco_code), 'h01);
    run(40, 1, 0);
    chk("t40_fail", int'(fail), 1);
    chk("t40_code", int'(dco_code), 'h01);
    chk("t40_busy", int'(busy), 0);
    run(20, 0, 0);
    chk("t20_fail", int'(fail), 1);
    chk("t20_code", int'(dco_code), 'h04);
    run(2, 1, 0);
    chk("t2_locked", int'(locked), 1);
    chk("t2_code", int'(dco_code), 'h00);
    run(250, 1, 0);
    chk("t250_fail", int'(fail), 1);
    chk("t250_code", int'(dco_code), 'h01);
    launch(32, 1, s);
    wait_until(s + 322 + 100);
    abort = 1;
    @(negedge clk);
    abort = 0;
    q.delete();
    chk("abort_busy", int'(busy), 0);
    chk("abort_code", int'(dco_code), 'h08);
    chk("abort_flags", int'(locked || fail), 0);
    abort = 1; start = 1;
    @(negedge clk);
    abort = 0; start = 0;
    @(negedge clk);
    chk("abort_over_start", int'(busy), 0);
    run(16, 1, 0);
    chk("after_abort_code", int'(dco_code), 'h10);
    launch(32, 1, s);
    wait_until(s + 322 + 30);
    rst_n = 0;
    #1;
    chk("midrst_code", int'(dco_code), 'h10);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_flags", int'(locked || fail), 0);
    chk("midrst_meas_count", int'(meas_count), 0);
    q.delete();
    @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);
    for (int n = 0; n < 12; n++) begin
      for (int i = 0; i < 9; i++) ptab[i] = $urandom_range(2, 130);
      r = $urandom_range(0, 8);
      tg = (n % 4 == 3) ? $urandom_range(0, 255) : 256 / ptab[r] + $urandom_range(0, 4) - 2;
      if (tg < 0) tg = 0;
      run(tg, (n % 4 == 3) ? 15 : $urandom_range(0, 3), n[0]);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
